// File: rtl/switch_debouncer.sv
// Switch conditioner: two-flop synchroniser, bounce filter that needs
// STABLE_CYCLES consecutive samples of a new level, edge strobes and a press toggle.
module switch_debouncer #(
  parameter  int STABLE_CYCLES = 1000000,
  localparam int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic SWITCH,
  output logic SWITCH_OUT,
  output logic RISE,
  output logic FALL,
  output logic TOGGLE
);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_CHK_HIGH,
    ST_HIGH,
    ST_CHK_LOW
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            s1_q;
  logic            s2_q;
  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;
  logic            toggle_q;

  // The pad is asynchronous; only s2_q is safe to use in the filter below.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= SWITCH;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_LOW: begin
          if (s2_q) begin
            state_q <= ST_CHK_HIGH;
            cnt_q   <= CNT_ONE;
          end
        end
        // Any reversal while qualifying discards the progress made so far.
        ST_CHK_HIGH: begin
          if (!s2_q) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ST_HIGH;
            cnt_q    <= '0;
            level_q  <= 1'b1;
            rise_q   <= 1'b1;
            toggle_q <= ~toggle_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s2_q) begin
            state_q <= ST_CHK_LOW;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_CHK_LOW: begin
          if (s2_q) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign SWITCH_OUT = level_q;
  assign RISE       = rise_q;
  assign FALL       = fall_q;
  assign TOGGLE     = toggle_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with STABLE_CYCLES=4: expected strobes are queued
// when the switch is settled and matched against strobes seen on the outputs.
module tb_switch_debouncer;

  localparam int ST = 4;

  logic CLOCK;
  logic RESET_N;
  logic SWITCH;
  logic SWITCH_OUT;
  logic RISE;
  logic FALL;
  logic TOGGLE;

  typedef struct {
    bit is_rise;
    int at_cyc;
    bit toggle;
    bit level;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   exp_toggle = 1'b0;

  switch_debouncer #(.STABLE_CYCLES(ST)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .SWITCH    (SWITCH),
    .SWITCH_OUT(SWITCH_OUT),
    .RISE      (RISE),
    .FALL      (FALL),
    .TOGGLE    (TOGGLE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge CLOCK) begin
    if (RESET_N && (RISE || FALL)) begin
      check("strobe_exclusive", 32'(RISE && FALL), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'({RISE, FALL}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind",   32'(RISE),       32'(e.is_rise));
        check("strobe_cycle",  32'(cyc),        32'(e.at_cyc));
        check("strobe_toggle", 32'(TOGGLE),     32'(e.toggle));
        check("strobe_level",  32'(SWITCH_OUT), 32'(e.level));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Queue the strobe a clean settle to v must produce, then wait it out.
  task automatic push_expect(input bit v);
    exp_t e;
    if (v) exp_toggle = ~exp_toggle;
    e.is_rise = v;
    e.at_cyc  = cyc + ST + 2;
    e.toggle  = exp_toggle;
    e.level   = v;
    sb.push_back(e);
  endtask

  task automatic settle(input bit v, input string tag);
    @(negedge CLOCK);
    SWITCH = v;
    push_expect(v);
    wait_cyc(ST + 4);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_level"},   32'(SWITCH_OUT), 32'(v));
    check({tag, "_toggle"},  32'(TOGGLE),     32'(exp_toggle));
  endtask

  initial begin
    RESET_N = 1'b0;
    SWITCH  = 1'b0;
    #1;
    check("reset_out",    32'(SWITCH_OUT), 32'd0);
    check("reset_rise",   32'(RISE),       32'd0);
    check("reset_fall",   32'(FALL),       32'd0);
    check("reset_toggle", 32'(TOGGLE),     32'd0);
    #19;
    RESET_N = 1'b1;
    wait_cyc(3);
    check("idle_out", 32'(SWITCH_OUT), 32'd0);

    settle(1'b1, "clean_press");
    settle(1'b0, "release1");

    // Three-cycle pulse is too short to qualify.
    @(negedge CLOCK);
    SWITCH = 1'b1;
    wait_cyc(3);
    SWITCH = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      check("glitch_out",    32'(SWITCH_OUT), 32'd0);
      check("glitch_toggle", 32'(TOGGLE),     32'(exp_toggle));
    end

    // Bounce: two-cycle levels, then a settled press.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      SWITCH = ~SWITCH;
      @(negedge CLOCK);
    end
    check("bounce_out", 32'(SWITCH_OUT), 32'd0);
    settle(1'b1, "bounce_press");
    settle(1'b0, "release2");
    settle(1'b1, "third_press");
    settle(1'b0, "release3");

    // Reset partway through qualifying a press.
    @(negedge CLOCK);
    SWITCH = 1'b1;
    wait_cyc(4);
    #2;
    RESET_N = 1'b0;
    #1;
    check("midreset_out",    32'(SWITCH_OUT), 32'd0);
    check("midreset_rise",   32'(RISE),       32'd0);
    check("midreset_toggle", 32'(TOGGLE),     32'd0);
    exp_toggle = 1'b0;
    wait_cyc(2);
    RESET_N = 1'b1;
    push_expect(1'b1);
    wait_cyc(ST + 4);
    check("post_reset_drained", 32'(sb.size()),  32'd0);
    check("post_reset_level",   32'(SWITCH_OUT), 32'd1);
    check("post_reset_toggle",  32'(TOGGLE),     32'd1);

    settle(1'b0, "final_release");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
